// File: rtl/code_tracking_loop.sv
// Code tracking loop: early-minus-late code discriminator, fixed-step code correction and
// prompt-power lock/loss detection. Define TRACKER_REACQ_EN for a one-shot re-seek on loss.

module code_tracking_loop #(
    parameter int unsigned I2Q2_WIDTH   = 38,
    parameter int unsigned CS_WIDTH     = 15,
    parameter int unsigned CS_MAX       = 16367,
    parameter int unsigned DOPP_WIDTH   = 16,
    parameter int unsigned CS_STEP      = 1,
    parameter int unsigned THRESH_SHIFT = 3,
    parameter int unsigned LOCK_THRESH  = 1 << 20,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned LOSS_COUNT   = 3
) (
    input  logic                  clk_i,
    input  logic                  global_reset_ni,
    input  logic                  enable_i,
    input  logic                  acquisition_complete_i,
    input  logic [CS_WIDTH-1:0]   acq_peak_code_shift_i,
    input  logic [DOPP_WIDTH-1:0] acq_peak_doppler_i,
    input  logic                  i2q2_valid_i,
    input  logic [I2Q2_WIDTH-1:0] i2q2_early_i,
    input  logic [I2Q2_WIDTH-1:0] i2q2_prompt_i,
    input  logic [I2Q2_WIDTH-1:0] i2q2_late_i,
    output logic                  seek_en_o,
    output logic [CS_WIDTH-1:0]   seek_target_o,
    output logic [DOPP_WIDTH-1:0] doppler_early_o,
    output logic [DOPP_WIDTH-1:0] doppler_prompt_o,
    output logic [DOPP_WIDTH-1:0] doppler_late_o,
    output logic                  locked_o,
    output logic                  loss_pulse_o
);

    // Modular step constants kept within CS_WIDTH: every intermediate result stays below CS_MAX+1.
    localparam logic [CS_WIDTH-1:0]   CsStep   = CS_WIDTH'(CS_STEP);
    localparam logic [CS_WIDTH-1:0]   CsWrap   = CS_WIDTH'(CS_MAX + 1 - CS_STEP);
    localparam logic [CS_WIDTH-1:0]   CsIncLim = CS_WIDTH'(CS_MAX - CS_STEP);
    localparam logic [I2Q2_WIDTH-1:0] LockThr  = I2Q2_WIDTH'(LOCK_THRESH);
    localparam logic [3:0]            LockCnt  = 4'(LOCK_COUNT);
    localparam logic [3:0]            LossCnt  = 4'(LOSS_COUNT);

`ifdef TRACKER_REACQ_EN
    typedef enum logic [2:0] {StIdle, StTrack, StCalc, StSeek, StReacq} state_e;
`else
    typedef enum logic [2:0] {StIdle, StTrack, StCalc, StSeek} state_e;
`endif

    state_e                state_q;
    logic [CS_WIDTH-1:0]   cs_q;
    logic [CS_WIDTH-1:0]   seek_target_q;
    logic [DOPP_WIDTH-1:0] dopp_q;
    logic [I2Q2_WIDTH-1:0] early_q, prompt_q, late_q;
    logic [3:0]            good_cnt_q, bad_cnt_q;
    logic                  seek_en_q, locked_q, loss_pulse_q;
`ifdef TRACKER_REACQ_EN
    logic [CS_WIDTH-1:0]   lock_cs_q;
    logic                  reacq_ok_q;
`endif

    logic [I2Q2_WIDTH-1:0] abs_diff, deadband;
    logic [CS_WIDTH-1:0]   cs_dec, cs_inc, cs_corr;
    logic [3:0]            good_inc, bad_inc;
    logic                  p_good;

    always_comb begin
        abs_diff = (early_q >= late_q) ? early_q - late_q : late_q - early_q;
        deadband = prompt_q >> THRESH_SHIFT;
        cs_dec   = (cs_q >= CsStep) ? cs_q - CsStep : cs_q + CsWrap;
        cs_inc   = (cs_q <= CsIncLim) ? cs_q + CsStep : cs_q - CsWrap;
        cs_corr  = cs_q;
        if (abs_diff > deadband) begin
            cs_corr = (early_q > late_q) ? cs_dec : cs_inc;
        end
        p_good   = prompt_q >= LockThr;
        good_inc = (good_cnt_q == 4'hf) ? good_cnt_q : good_cnt_q + 4'd1;
        bad_inc  = (bad_cnt_q == 4'hf) ? bad_cnt_q : bad_cnt_q + 4'd1;
    end

    always_ff @(posedge clk_i or negedge global_reset_ni) begin
        if (!global_reset_ni) begin
            state_q       <= StIdle;
            cs_q          <= '0;
            seek_target_q <= '0;
            dopp_q        <= '0;
            early_q       <= '0;
            prompt_q      <= '0;
            late_q        <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            seek_en_q     <= 1'b0;
            locked_q      <= 1'b0;
            loss_pulse_q  <= 1'b0;
`ifdef TRACKER_REACQ_EN
            lock_cs_q     <= '0;
            reacq_ok_q    <= 1'b0;
`endif
        end else begin
            seek_en_q    <= 1'b0;
            loss_pulse_q <= 1'b0;
`ifdef TRACKER_REACQ_EN
            if (locked_q) lock_cs_q <= cs_q;
`endif
            if (!enable_i) begin
                state_q    <= StIdle;
                locked_q   <= 1'b0;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
`ifdef TRACKER_REACQ_EN
                reacq_ok_q <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (acquisition_complete_i) begin
                            cs_q          <= acq_peak_code_shift_i;
                            dopp_q        <= acq_peak_doppler_i;
                            seek_target_q <= acq_peak_code_shift_i;
                            seek_en_q     <= 1'b1;
                            good_cnt_q    <= '0;
                            bad_cnt_q     <= '0;
`ifdef TRACKER_REACQ_EN
                            reacq_ok_q    <= 1'b0;
`endif
                            state_q       <= StSeek;
                        end
                    end
                    StTrack: begin
                        if (i2q2_valid_i) begin
                            early_q  <= i2q2_early_i;
                            prompt_q <= i2q2_prompt_i;
                            late_q   <= i2q2_late_i;
                            state_q  <= StCalc;
                        end
                    end
                    StCalc: begin
                        cs_q <= cs_corr;
                        if (p_good) begin
                            good_cnt_q <= good_inc;
                            bad_cnt_q  <= '0;
                            if (good_inc >= LockCnt) begin
                                locked_q   <= 1'b1;
`ifdef TRACKER_REACQ_EN
                                reacq_ok_q <= 1'b1;
`endif
                            end
                        end else begin
                            good_cnt_q <= '0;
                            bad_cnt_q  <= bad_inc;
                        end
                        if (!p_good && bad_inc >= LossCnt) begin
                            locked_q     <= 1'b0;
                            loss_pulse_q <= 1'b1;
                            good_cnt_q   <= '0;
                            bad_cnt_q    <= '0;
                            state_q      <= StIdle;
`ifdef TRACKER_REACQ_EN
                            // Only one re-seek per lock: the flag is re-armed by the next lock.
                            if (reacq_ok_q) begin
                                cs_q          <= lock_cs_q;
                                seek_target_q <= lock_cs_q;
                                seek_en_q     <= 1'b1;
                                reacq_ok_q    <= 1'b0;
                                state_q       <= StReacq;
                            end
`endif
                        end else begin
                            seek_target_q <= cs_corr;
                            seek_en_q     <= 1'b1;
                            state_q       <= StSeek;
                        end
                    end
                    StSeek:  state_q <= StTrack;
`ifdef TRACKER_REACQ_EN
                    StReacq: state_q <= StTrack;
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign seek_en_o        = seek_en_q;
    assign seek_target_o    = seek_target_q;
    assign doppler_early_o  = dopp_q;
    assign doppler_prompt_o = dopp_q;
    assign doppler_late_o   = dopp_q;
    assign locked_o         = locked_q;
    assign loss_pulse_o     = loss_pulse_q;

endmodule
